// File: rtl/issue_pkg.sv
// Shared stage encodings and constants for the instruction issue unit.
package issue_pkg;
   typedef enum logic [2:0] {
      STG_FETCH  = 3'd0,
      STG_DECODE = 3'd1,
      STG_EXEC   = 3'd2,
      STG_MEM    = 3'd3,
      STG_WB     = 3'd4
   } stage_t;

   localparam int          PC_INC       = 4;
   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
endpackage

// File: rtl/pc_sequencer.sv
// Next-PC selection resolved in Execute: sequential PC+4 or word-aligned branch target.
// Fault latches any misaligned taken target until reset.
module pc_sequencer
   import issue_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              resolve,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              fault
);
   logic [ADDR_W-1:0] aligned_target;
   logic [ADDR_W-1:0] selected;
   logic              misaligned;

   always_comb begin
      aligned_target = {branch_target[ADDR_W-1:2], 2'b00};
      misaligned     = |branch_target[1:0];
      selected       = branch_taken ? aligned_target : pc + ADDR_W'(PC_INC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_pc <= RESET_PC;
         fault   <= 1'b0;
      end else if (resolve) begin
         next_pc <= selected;
         if (branch_taken && misaligned)
            fault <= 1'b1;
      end
   end
endmodule

// File: rtl/instruction_issue_unit.sv
// Fetches ROM words and holds each one for a 5-stage pass, driving Stage/PC/Retire.
// Build option ISSUE_PREFETCH_EN: fetch next-PC during Memory into a one-entry buffer.
module instruction_issue_unit
   import issue_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [31:0]       NOP_WORD = NOP_WORD_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic [ADDR_W-1:0] ROM_Addr,
   output logic              ROM_Read,
   input  logic [31:0]       ROM_Data,
   input  logic              ROM_Ack,
   input  logic              Hold,
   input  logic              Branch_Taken,
   input  logic [ADDR_W-1:0] Branch_Target,
   output logic [31:0]       Instruction,
   output logic              Instruction_Valid,
   output logic [2:0]        Stage,
   output logic [ADDR_W-1:0] PC,
   output logic              Retire,
   output logic              Fault
);
   stage_t            stage, stage_nxt;
   logic              captured;
   logic              word_in;
   logic              word_rdy;
   logic              resolve;
   logic [31:0]       fetch_dat;
   logic [ADDR_W-1:0] next_pc;
`ifdef ISSUE_PREFETCH_EN
   logic              buf_vld;
   logic [31:0]       buf_dat;
`endif

   assign word_in = ROM_Read && ROM_Ack;
   assign resolve = (stage == STG_EXEC) && !Hold;
   assign Stage   = stage;

`ifdef ISSUE_PREFETCH_EN
   // A prefetch targets next-PC; once in Fetch, PC already equals that address.
   assign word_rdy  = word_in || buf_vld;
   assign fetch_dat = buf_vld ? buf_dat : ROM_Data;
   assign ROM_Addr  = (stage == STG_FETCH) ? PC : next_pc;
`else
   assign word_rdy  = word_in;
   assign fetch_dat = ROM_Data;
   assign ROM_Addr  = PC;
`endif

   pc_sequencer #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_seq (
      .clk           (Clock),
      .rst           (Reset),
      .resolve       (resolve),
      .branch_taken  (Branch_Taken),
      .branch_target (Branch_Target),
      .pc            (PC),
      .next_pc       (next_pc),
      .fault         (Fault)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) stage <= STG_FETCH;
      else       stage <= stage_nxt;
   end

   always_comb begin
      stage_nxt = stage;
      case (stage)
         STG_FETCH:  if (!Hold && (captured || word_rdy)) stage_nxt = STG_DECODE;
         STG_DECODE: if (!Hold) stage_nxt = STG_EXEC;
         STG_EXEC:   if (!Hold) stage_nxt = STG_MEM;
         STG_MEM:    if (!Hold) stage_nxt = STG_WB;
         STG_WB:     if (!Hold) stage_nxt = STG_FETCH;
         default:    stage_nxt = STG_FETCH;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         PC                <= RESET_PC;
         Instruction       <= NOP_WORD;
         Instruction_Valid <= 1'b0;
         ROM_Read          <= 1'b0;
         Retire            <= 1'b0;
         captured          <= 1'b0;
`ifdef ISSUE_PREFETCH_EN
         buf_vld           <= 1'b0;
         buf_dat           <= '0;
`endif
      end else begin
         Retire <= 1'b0;
         case (stage)
            STG_FETCH: begin
               if (captured) begin
                  if (!Hold) captured <= 1'b0;
               end else if (word_rdy) begin
                  Instruction       <= fetch_dat;
                  Instruction_Valid <= 1'b1;
                  ROM_Read          <= 1'b0;
                  captured          <= Hold;
`ifdef ISSUE_PREFETCH_EN
                  buf_vld           <= 1'b0;
`endif
               end else if (!ROM_Read) begin
                  // Only after reset or recovery; normal passes request on the WriteBack edge.
                  ROM_Read <= 1'b1;
               end
            end
            STG_DECODE: ;
            STG_EXEC: begin
`ifdef ISSUE_PREFETCH_EN
               if (!Hold && !Branch_Taken) ROM_Read <= 1'b1;
`endif
            end
            STG_MEM: begin
`ifdef ISSUE_PREFETCH_EN
               if (word_in) begin
                  buf_dat  <= ROM_Data;
                  buf_vld  <= 1'b1;
                  ROM_Read <= 1'b0;
               end
`endif
            end
            STG_WB: begin
`ifdef ISSUE_PREFETCH_EN
               if (word_in) begin
                  buf_dat  <= ROM_Data;
                  buf_vld  <= 1'b1;
                  ROM_Read <= 1'b0;
               end
`endif
               if (!Hold) begin
                  PC                <= next_pc;
                  Retire            <= 1'b1;
                  Instruction_Valid <= 1'b0;
                  Instruction       <= NOP_WORD;
`ifdef ISSUE_PREFETCH_EN
                  if (!buf_vld && !ROM_Read) ROM_Read <= 1'b1;
`else
                  ROM_Read          <= 1'b1;
`endif
               end
            end
            default: begin
               Instruction_Valid <= 1'b0;
               Instruction       <= NOP_WORD;
               captured          <= 1'b0;
               ROM_Read          <= 1'b1;
            end
         endcase
      end
   end
endmodule
